// File: rtl/timed_cfg_scheduler_if.sv
// timed_cfg_if: host command channel and register write port of the timed config scheduler
interface timed_cfg_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_timed;
  logic [55:0] cmd_time;
  logic [8:0]  cmd_waddr;
  logic [31:0] cmd_wdata;
  logic        cfg_wreq;
  logic [8:0]  cfg_waddr;
  logic [31:0] cfg_wdata;
  logic        cfg_wack;
  modport master (
    output cmd_valid, cmd_timed, cmd_time, cmd_waddr, cmd_wdata, cfg_wack,
    input  cmd_ready, cfg_wreq, cfg_waddr, cfg_wdata
  );
  modport slave (
    input  cmd_valid, cmd_timed, cmd_time, cmd_waddr, cmd_wdata, cfg_wack,
    output cmd_ready, cfg_wreq, cfg_waddr, cfg_wdata
  );
endinterface

// File: rtl/timed_cfg_scheduler.sv
// timed_cfg_scheduler: queues config writes and issues each at its target ADC sample index
module timed_cfg_scheduler #(
  parameter int DEPTH       = 8,
  parameter int LATE_POLICY = 1,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                     user_clk,
  input  logic                     user_rst,
  timed_cfg_if.slave               bus,
  input  logic [55:0]              sample_idx,
  input  logic                     sample_valid,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     late_pulse,
  output logic                     timeout_pulse,
  output logic [15:0]              late_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT_TIME, ISSUE, WAIT_ACK} state_t;
  typedef struct packed {
    logic        timed;
    logic [55:0] t;
    logic [8:0]  waddr;
    logic [31:0] wdata;
  } cmd_t;
  cmd_t        mem [DEPTH];
  cmd_t        head;
  logic [AW-1:0] wptr, rptr;
  logic [7:0]  cnt;
  state_t      state;
  logic        push, pop, due, late, ack_to;
  assign head          = mem[rptr];
  assign bus.cmd_ready = !user_rst && !flush && level < (AW+1)'(DEPTH);
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign due           = !head.timed || (sample_valid && sample_idx == head.t);
  assign late          = head.timed && sample_valid && sample_idx > head.t;
  assign ack_to        = cnt == 8'(ACK_TIMEOUT - 1);
  assign late_pulse    = state == WAIT_TIME && late && !flush && !user_rst;
  assign timeout_pulse = state == WAIT_ACK && !bus.cfg_wack && ack_to && !flush && !user_rst;
  assign pop           = (state == WAIT_TIME && late && LATE_POLICY == 0) ||
                         (state == WAIT_ACK && (bus.cfg_wack || ack_to));
  assign busy          = state != IDLE;
  always_ff @(posedge user_clk)
    if (push) mem[wptr] <= '{bus.cmd_timed, bus.cmd_time, bus.cmd_waddr, bus.cmd_wdata};
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state         <= IDLE;
      wptr          <= '0;
      rptr          <= '0;
      level         <= '0;
      cnt           <= '0;
      late_count    <= '0;
      bus.cfg_wreq  <= 1'b0;
      bus.cfg_waddr <= '0;
      bus.cfg_wdata <= '0;
    end else if (flush) begin
      state        <= IDLE;
      wptr         <= '0;
      rptr         <= '0;
      level        <= '0;
      bus.cfg_wreq <= 1'b0;
    end else begin
      wptr         <= wptr + AW'(push);
      rptr         <= rptr + AW'(pop);
      level        <= level + (AW+1)'(push) - (AW+1)'(pop);
      bus.cfg_wreq <= 1'b0;
      if (late_pulse && late_count != 16'hFFFF) late_count <= late_count + 16'd1;
      case (state)
        IDLE:      if (level != 0) state <= WAIT_TIME;
        WAIT_TIME: if (due || (late && LATE_POLICY != 0)) begin
                     state         <= ISSUE;
                     bus.cfg_wreq  <= 1'b1;
                     bus.cfg_waddr <= head.waddr;
                     bus.cfg_wdata <= head.wdata;
                   end else if (late) state <= IDLE;
        ISSUE:     begin
                     state <= WAIT_ACK;
                     cnt   <= '0;
                   end
        WAIT_ACK:  if (bus.cfg_wack || ack_to) state <= IDLE;
                   else cnt <= cnt + 8'd1;
      endcase
    end
  end
endmodule

// File: tb/tb_timed_cfg_scheduler.sv
// tb_timed_cfg_scheduler: directed checks of timing, late policy, ordering, timeout, flush and reset
module tb_timed_cfg_scheduler;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [55:0] sample_idx;
  logic        sample_valid, flush;
  logic [3:0]  level0, level1;
  logic        busy0, busy1, lp0, lp1, tp0, tp1;
  logic [15:0] lc0, lc1;
  timed_cfg_if b0();
  timed_cfg_if b1();
  timed_cfg_scheduler #(.DEPTH(8), .LATE_POLICY(1), .ACK_TIMEOUT(16)) u0 (
    .user_clk(clk), .user_rst(rst), .bus(b0), .sample_idx(sample_idx), .sample_valid(sample_valid),
    .flush(flush), .level(level0), .busy(busy0), .late_pulse(lp0), .timeout_pulse(tp0), .late_count(lc0));
  timed_cfg_scheduler #(.DEPTH(8), .LATE_POLICY(0), .ACK_TIMEOUT(16)) u1 (
    .user_clk(clk), .user_rst(rst), .bus(b1), .sample_idx(sample_idx), .sample_valid(sample_valid),
    .flush(flush), .level(level1), .busy(busy1), .late_pulse(lp1), .timeout_pulse(tp1), .late_count(lc1));
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int         wq0[$], to0[$], acc0[$];
  logic [8:0] wa0[$];
  int         wn1 = 0, lp0n = 0, lp1n = 0;
  always @(negedge clk) begin
    if (b0.cfg_wreq) begin
      wq0.push_back(cyc);
      wa0.push_back(b0.cfg_waddr);
    end
    if (b1.cfg_wreq) wn1++;
    if (lp0) lp0n++;
    if (lp1) lp1n++;
    if (tp0) to0.push_back(cyc);
    if (b0.cmd_valid && b0.cmd_ready) acc0.push_back(cyc);
  end
  int n_cmp = 0, n_bad = 0;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push0(logic timed, logic [55:0] t, logic [8:0] a, logic [31:0] d);
    b0.cmd_valid = 1'b1;
    b0.cmd_timed = timed;
    b0.cmd_time  = t;
    b0.cmd_waddr = a;
    b0.cmd_wdata = d;
    step();
    b0.cmd_valid = 1'b0;
  endtask
  int c0, m, s[9];
  initial begin
    sample_idx = '0; sample_valid = 1'b0; flush = 1'b0;
    b0.cmd_valid = 1'b0; b0.cmd_timed = 1'b0; b0.cmd_time = '0; b0.cmd_waddr = '0; b0.cmd_wdata = '0; b0.cfg_wack = 1'b0;
    b1.cmd_valid = 1'b0; b1.cmd_timed = 1'b0; b1.cmd_time = '0; b1.cmd_waddr = '0; b1.cmd_wdata = '0; b1.cfg_wack = 1'b0;
    step(2);
    check("rst_ready", b0.cmd_ready, 0);
    check("rst_level", level0, 0);
    check("rst_busy", busy0, 0);
    check("rst_wreq", b0.cfg_wreq, 0);
    check("rst_lcount", lc0, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", b0.cmd_ready, 1);
    c0 = cyc;
    push0(1'b0, 56'd0, 9'd13, 32'h0000_0010);
    check("imm_level1", level0, 1);
    step(2);
    check("imm_wreq", b0.cfg_wreq, 1);
    check("imm_waddr", b0.cfg_waddr, 13);
    check("imm_wdata", b0.cfg_wdata, 32'h10);
    step();
    b0.cfg_wack = 1'b1;
    check("imm_level_wait", level0, 1);
    step();
    b0.cfg_wack = 1'b0;
    check("imm_level0", level0, 0);
    check("imm_busy0", busy0, 0);
    check("imm_nwreq", wq0.size(), 1);
    check("imm_latency", wq0.size() > 0 ? wq0[0] - c0 : -1, 3);
    wq0.delete();
    sample_valid = 1'b1;
    sample_idx   = 56'd990;
    b0.cfg_wack  = 1'b1;
    push0(1'b1, 56'd1000, 9'd20, 32'hA5);
    for (int k = 1; k <= 20; k++) begin
      sample_idx = 56'(990 + k);
      if (k == 10) m = cyc;
      step();
    end
    sample_valid = 1'b0;
    b0.cfg_wack  = 1'b0;
    check("timed_nwreq", wq0.size(), 1);
    check("timed_cycle", wq0.size() > 0 ? wq0[0] - m : -1, 1);
    check("timed_nolate", lp0n, 0);
    check("timed_lcount", lc0, 0);
    wq0.delete(); wa0.delete();
    sample_idx = 56'd600; sample_valid = 1'b1;
    b0.cfg_wack = 1'b1; b1.cfg_wack = 1'b1;
    b1.cmd_valid = 1'b1; b1.cmd_timed = 1'b1; b1.cmd_time = 56'd500; b1.cmd_waddr = 9'd33; b1.cmd_wdata = 32'h33;
    push0(1'b1, 56'd500, 9'd33, 32'h33);
    b1.cmd_valid = 1'b0;
    step(8);
    sample_valid = 1'b0; b0.cfg_wack = 1'b0; b1.cfg_wack = 1'b0;
    check("late1_pulses", lp0n, 1);
    check("late1_lcount", lc0, 1);
    check("late1_nwreq", wq0.size(), 1);
    check("late1_addr", wa0.size() > 0 ? wa0[0] : 9'h1FF, 33);
    check("late1_level", level0, 0);
    check("late0_pulses", lp1n, 1);
    check("late0_lcount", lc1, 1);
    check("late0_nwreq", wn1, 0);
    check("late0_level", level1, 0);
    wq0.delete(); wa0.delete(); acc0.delete();
    b0.cfg_wack = 1'b1;
    for (int i = 0; i < 8; i++) push0(1'b1, 56'(100 + i), 9'(100 + i), 32'(i));
    b0.cmd_valid = 1'b1; b0.cmd_timed = 1'b1; b0.cmd_time = 56'd108; b0.cmd_waddr = 9'd108; b0.cmd_wdata = 32'd8;
    #1;
    check("full_level", level0, 8);
    check("full_ready", b0.cmd_ready, 0);
    step();
    check("full_ready_hold", b0.cmd_ready, 0);
    for (int k = 0; k < 9; k++) begin
      sample_idx = 56'(100 + k);
      sample_valid = 1'b1;
      s[k] = cyc;
      step();
      sample_valid = 1'b0;
      if (acc0.size() == 9) b0.cmd_valid = 1'b0;
      repeat (5) begin
        step();
        if (acc0.size() == 9) b0.cmd_valid = 1'b0;
      end
    end
    b0.cmd_valid = 1'b0;
    check("order_nwreq", wq0.size(), 9);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("order_cyc%0d", k), wq0.size() > k ? wq0[k] - s[k] : -1, 1);
      check($sformatf("order_addr%0d", k), wa0.size() > k ? wa0[k] : 9'h1FF, 9'(100 + k));
    end
    check("refill_accepts", acc0.size(), 9);
    check("refill_cycle", acc0.size() > 8 ? acc0[8] - s[0] : -1, 3);
    check("order_level", level0, 0);
    check("order_lcount", lc0, 1);
    wq0.delete(); wa0.delete(); to0.delete();
    b0.cfg_wack = 1'b0;
    push0(1'b0, 56'd0, 9'd1, 32'd1);
    push0(1'b0, 56'd0, 9'd2, 32'd2);
    step(40);
    check("to_count", to0.size(), 2);
    check("to_first", (to0.size() > 0 && wq0.size() > 0) ? to0[0] - wq0[0] : -1, 16);
    check("to_next_issue", (to0.size() > 0 && wq0.size() > 1) ? wq0[1] - to0[0] : -1, 3);
    check("to_second", (to0.size() > 1 && wq0.size() > 1) ? to0[1] - wq0[1] : -1, 16);
    check("to_second_addr", wa0.size() > 1 ? wa0[1] : 9'h1FF, 2);
    check("to_level", level0, 0);
    push0(1'b0, 56'd0, 9'd3, 32'd3);
    step(2);
    b0.cfg_wack = 1'b1;
    step();
    b0.cfg_wack = 1'b0;
    step(20);
    check("issue_ack_ignored", to0.size(), 3);
    check("issue_ack_to", (to0.size() > 2 && wq0.size() > 2) ? to0[2] - wq0[2] : -1, 16);
    wq0.delete(); to0.delete(); acc0.delete();
    push0(1'b0, 56'd0, 9'd4, 32'd4);
    push0(1'b0, 56'd0, 9'd5, 32'd5);
    push0(1'b0, 56'd0, 9'd6, 32'd6);
    step();
    check("fl_busy_before", busy0, 1);
    check("fl_level_before", level0, 3);
    flush = 1'b1;
    b0.cmd_valid = 1'b1; b0.cmd_timed = 1'b0; b0.cmd_waddr = 9'd7;
    #1;
    check("fl_ready", b0.cmd_ready, 0);
    step();
    flush = 1'b0;
    b0.cmd_valid = 1'b0;
    check("fl_level", level0, 0);
    check("fl_busy", busy0, 0);
    b0.cfg_wack = 1'b1;
    step();
    b0.cfg_wack = 1'b0;
    step(20);
    check("fl_nwreq", wq0.size(), 1);
    check("fl_noto", to0.size(), 0);
    check("fl_accepts", acc0.size(), 3);
    check("fl_level_after", level0, 0);
    sample_valid = 1'b1;
    sample_idx = 56'd200;
    push0(1'b1, 56'd5000, 9'd8, 32'd8);
    push0(1'b1, 56'd5001, 9'd9, 32'd9);
    step(3);
    check("mid_level", level0, 2);
    rst = 1'b1;
    #1;
    check("rst2_ready", b0.cmd_ready, 0);
    step();
    sample_valid = 1'b0;
    check("rst2_level", level0, 0);
    check("rst2_busy", busy0, 0);
    check("rst2_wreq", b0.cfg_wreq, 0);
    check("rst2_waddr", b0.cfg_waddr, 0);
    check("rst2_wdata", b0.cfg_wdata, 0);
    check("rst2_lcount", lc0, 0);
    check("rst2_lcount1", lc1, 0);
    check("rst2_pulses", {lp0, tp0}, 0);
    rst = 1'b0;
    #1;
    check("rst2_ready_after", b0.cmd_ready, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/timed_cfg_scheduler.md
Name: timed_cfg_scheduler

Overview:
- Queues configuration writes, each tagged with a 56-bit sample-index timestamp or marked immediate.
- Issues each write to the block's user-side register write port at the exact ADC sample where it is due.
- Use cases: decimation ratio, filter mask/reset or correction-coefficient changes that must land sample-aligned.
- Sits between the host command path and the register block's user write port, in the user clock domain.

Parameters:
DEPTH, 8, command queue depth; power of two, 2..64
LATE_POLICY, 1, 1 = execute late command immediately; 0 = drop late command
ACK_TIMEOUT, 16, cycles to wait for cfg_wack before abandoning a write (1..255)

Ports:
user_clk  in  1  clock
user_rst  in  1  reset, synchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at rising edge
cmd_timed  in  1  1 = execute at cmd_time; 0 = execute as soon as at queue head
cmd_time  in  56  target sample index
cmd_waddr  in  9  register address to write
cmd_wdata  in  32  register data
sample_idx  in  56  current ADC sample index, qualified by sample_valid
sample_valid  in  1  sample_idx valid this cycle
flush  in  1  discard all queued commands and abort the current one
cfg_wreq  out  1  one-cycle write request to register port
cfg_waddr  out  9  write address, stable from request until ack/timeout
cfg_wdata  out  32  write data, same stability as cfg_waddr
cfg_wack  in  1  write acknowledge
level  out  $clog2(DEPTH)+1  queued command count, including the one in progress
busy  out  1  state != IDLE
late_pulse  out  1  one-cycle pulse when a timed command is found late
timeout_pulse  out  1  one-cycle pulse on ack timeout
late_count  out  16  late commands since reset; saturates at 16'hFFFF

Behaviour:
Reset (user_rst=1 at an edge):
- Queue is emptied; state goes to IDLE.
- cmd_ready, cfg_wreq, cfg_waddr, cfg_wdata, level, busy, late_pulse, timeout_pulse and late_count are all 0.
- cmd_ready stays 0 while user_rst is high and returns to 1 in the first cycle after.
- Reset mid-write abandons the write silently.

Queue:
- In-order FIFO; only the head is ever considered.
- cmd_ready = !user_rst && !flush && level < DEPTH.
- When full, cmd_ready is 0 even if a pop occurs that same cycle (no bypass).
- Push and pop in the same cycle leave level unchanged.
- The head entry is popped only on completion, drop or timeout.

State machine:
- IDLE: if level != 0, go to WAIT_TIME.
- WAIT_TIME: evaluates the head every cycle.
  - Untimed head: go to ISSUE.
  - Timed head, sample_valid && sample_idx == cmd_time: go to ISSUE.
  - Timed head, sample_valid && sample_idx > cmd_time (unsigned 56-bit): late. Pulse late_pulse and increment late_count (saturating). If LATE_POLICY=1, go to ISSUE; otherwise pop and go to IDLE.
  - sample_valid=0: hold.
- ISSUE:
  - cfg_wreq=1 for exactly this cycle.
  - cfg_waddr/cfg_wdata load from the head on entry to ISSUE and hold until the next ISSUE.
  - Go to WAIT_ACK; the ack counter is cleared.
- WAIT_ACK:
  - cfg_wack=1: pop, go to IDLE.
  - Otherwise increment the counter. On the ACK_TIMEOUT-th cycle without ack: pulse timeout_pulse, pop, go to IDLE.
  - cfg_wack in any other state is ignored.
  - An ack in the ISSUE cycle itself is ignored; the write then times out.

Latency:
- Untimed command accepted at edge t into an empty idle queue: cfg_wreq is high in cycle t+3 (IDLE at t+1, WAIT_TIME at t+2, ISSUE at t+3).
- Timed match sampled at edge m: cfg_wreq is high in cycle m+1.
- Back-to-back queued commands: minimum 4 cycles between cfg_wreq pulses, given ack in the cycle after the request.

Flush:
- At the next edge: queue emptied, state IDLE, level 0, no late/timeout pulses.
- A cfg_wreq already high in the flush cycle completes its cycle; its ack is ignored.
- A command offered during flush is not accepted.

Time:
- sample_idx is treated as monotonic; 56-bit wrap is not handled.
- A timed command already in the past when it reaches the head is handled as late on the first sample_valid.

Test Plan:
- Immediate: push untimed {waddr=13, wdata=32'h0000_0010} at cycle 0, ack 1 cycle after request -> cfg_wreq only in cycle 3 with waddr 13, wdata 16; level 1 until the pop, then 0.
- Timed: push timed cmd_time=1000, sample_idx stepping by 1 each cycle from 990 -> cfg_wreq in the cycle after sample_idx==1000 is sampled; no late_pulse; late_count 0.
- Late: push cmd_time=500 while sample_idx=600, LATE_POLICY=1 -> late_pulse once, late_count 1, write issued. With LATE_POLICY=0 -> late_pulse, late_count 1, no cfg_wreq, level back to 0.
- Full/order: push DEPTH=8 timed commands (times 100..107) plus a 9th -> cmd_ready 0 after the 8th, level 8; writes issue in order at 100..107; cmd_ready returns 1 after the first pop.
- Timeout: withhold cfg_wack -> timeout_pulse exactly 16 cycles after the ISSUE cycle, head popped, next command proceeds.
- Flush/reset: flush while in WAIT_ACK with 3 queued -> level 0, busy 0 next cycle, later ack ignored. Assert user_rst mid-queue -> all outputs 0, late_count 0.
